// File: rtl/sid_bus_master.sv
// sid_bus_master
// ---------------------------------------------------------------------------
// Host-side initiator for the SID register bus. The host queues write, read
// and wait commands, and this block replays them onto the SID port. Each bus
// access is aligned to the 1 MHz CLKen tick, so the SID sees C64-like timing.
//
// Parameters
//   FIFO_DEPTH : command queue depth (power of two, >= 2)
//   DELAY_W    : width of the wait tick count (>= 8, because it also carries
//                the write data byte)
//
// Ports
//   CLK, RSTn         : clock, asynchronous active-low reset
//   CLKen             : 1 MHz enable shared with the SID
//   CMD_VALID/READY   : command handshake (READY = queue not full)
//   CMD_TYPE          : 0 write, 1 read, 2 wait, 3 reserved (no-op)
//   CMD_ADDR/CMD_DATA : register address / write byte or wait tick count
//   SID_WR/ADDR/DATAW : bus towards the SID
//   SID_DATAR         : combinational read data from the SID
//   RD_VALID/ADDR/DATA: one-cycle read completion
//   BUSY, LEVEL       : activity flag and queue occupancy
//
// Configuration macro: SID_BUS_MASTER_READ_EN
//   Defined   : read commands access the bus and report RD_VALID.
//   Undefined : reads are dropped as no-ops, RD_* outputs are tied to 0 and
//               the read data register is not built.
// ---------------------------------------------------------------------------
module sid_bus_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int DELAY_W    = 16
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic                          CLKen,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic [1:0]                    CMD_TYPE,
    input  logic [4:0]                    CMD_ADDR,
    input  logic [DELAY_W-1:0]            CMD_DATA,
    output logic                          SID_WR,
    output logic [4:0]                    SID_ADDR,
    output logic [7:0]                    SID_DATAW,
    input  logic [7:0]                    SID_DATAR,
    output logic                          RD_VALID,
    output logic [4:0]                    RD_ADDR,
    output logic [7:0]                    RD_DATA,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 2 + 5 + DELAY_W;
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    localparam logic [1:0] T_WRITE = 2'd0;
    localparam logic [1:0] T_READ  = 2'd1;
    localparam logic [1:0] T_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    logic [CW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           ready_q;
    logic           empty;
    logic           full;
    logic           cmd_keep;
    logic           push_en;
    logic           pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign CMD_READY = ready_q && !full;
    assign LEVEL     = count_q;

    // Commands that never touch the bus and take no tick are accepted but
    // not stored, so they cannot cost an FSM cycle between two accesses.
`ifdef SID_BUS_MASTER_READ_EN
    assign cmd_keep = (CMD_TYPE == T_WRITE) || (CMD_TYPE == T_READ) ||
                      (CMD_TYPE == T_WAIT);
`else
    assign cmd_keep = (CMD_TYPE == T_WRITE) || (CMD_TYPE == T_WAIT);
`endif

    assign push_en = CMD_VALID && CMD_READY && cmd_keep;

    // Storage has no reset so it maps onto distributed/block RAM.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            mem[wr_ptr_q] <= {CMD_TYPE, CMD_ADDR, CMD_DATA};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_en, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [CW-1:0]        cmd_q, cmd_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic                 sid_wr_q, sid_wr_d;
    logic [4:0]           sid_addr_q, sid_addr_d;
    logic [7:0]           sid_dataw_q, sid_dataw_d;
    logic                 rd_pend_d;
    logic                 advance;

    logic [1:0]           cmd_type;
    logic [4:0]           cmd_addr;
    logic [DELAY_W-1:0]   cmd_data;

    assign cmd_type = cmd_q[CW-1 -: 2];
    assign cmd_addr = cmd_q[DELAY_W +: 5];
    assign cmd_data = cmd_q[DELAY_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sid_wr_d    = 1'b0;
        sid_addr_d  = sid_addr_q;
        sid_dataw_d = sid_dataw_q;
        rd_pend_d   = 1'b0;
        advance     = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                advance = 1'b1;
            end
            ST_ISSUE: begin
                case (cmd_type)
                    T_WRITE: begin
                        if (CLKen) begin
                            sid_wr_d    = 1'b1;
                            sid_addr_d  = cmd_addr;
                            sid_dataw_d = cmd_data[7:0];
                            advance     = 1'b1;
                        end
                    end
`ifdef SID_BUS_MASTER_READ_EN
                    T_READ: begin
                        if (CLKen) begin
                            sid_addr_d = cmd_addr;
                            rd_pend_d  = 1'b1;
                            advance    = 1'b1;
                        end
                    end
`endif
                    T_WAIT: begin
                        // Waits need no tick to start; counting begins in WAIT.
                        cnt_d   = cmd_data;
                        state_d = ST_WAIT;
                    end
                    default: begin
                        advance = 1'b1;
                    end
                endcase
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else if (CLKen) begin
                    cnt_d = cnt_q - DELAY_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared "next command or idle" step used by every completion path.
        if (advance) begin
            if (!empty) begin
                pop     = 1'b1;
                state_d = ST_ISSUE;
            end else begin
                state_d = ST_IDLE;
            end
        end

        cmd_d = pop ? mem[rd_ptr_q] : cmd_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            sid_wr_q    <= 1'b0;
            sid_addr_q  <= '0;
            sid_dataw_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= 1'b1;
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            sid_wr_q    <= sid_wr_d;
            sid_addr_q  <= sid_addr_d;
            sid_dataw_q <= sid_dataw_d;
        end
    end

    assign SID_WR    = sid_wr_q;
    assign SID_ADDR  = sid_addr_q;
    assign SID_DATAW = sid_dataw_q;
    assign BUSY      = !empty || (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Read completion
    // ------------------------------------------------------------------
`ifdef SID_BUS_MASTER_READ_EN
    logic       rd_pend_q;
    logic       rd_valid_q, rd_valid_d;
    logic [4:0] rd_addr_q, rd_addr_d;
    logic [7:0] rd_data_q, rd_data_d;

    // rd_pend_q marks the address cycle; SID_DATAR is captured at its end.
    always_comb begin
        rd_valid_d = rd_pend_q;
        rd_addr_d  = rd_pend_q ? sid_addr_q : rd_addr_q;
        rd_data_d  = rd_pend_q ? SID_DATAR  : rd_data_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign RD_VALID = rd_valid_q;
    assign RD_ADDR  = rd_addr_q;
    assign RD_DATA  = rd_data_q;
`else
    logic unused_rd;
    assign unused_rd = ^{SID_DATAR, rd_pend_d};

    assign RD_VALID = 1'b0;
    assign RD_ADDR  = '0;
    assign RD_DATA  = '0;
`endif

endmodule

// File: tb/tb_sid_bus_master.sv
// Directed testbench for sid_bus_master (default parameters).
// A monitor logs every SID_WR pulse and RD_VALID pulse with its cycle
// number; each test task pushes commands and compares the log and the
// outputs against hand-computed values.
module tb_sid_bus_master;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b1;
    logic        CLKen = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE = 2'd0;
    logic [4:0]  CMD_ADDR = 5'd0;
    logic [15:0] CMD_DATA = 16'd0;
    logic        SID_WR;
    logic [4:0]  SID_ADDR;
    logic [7:0]  SID_DATAW;
    logic [7:0]  SID_DATAR;
    logic        RD_VALID;
    logic [4:0]  RD_ADDR;
    logic [7:0]  RD_DATA;
    logic        BUSY;
    logic [4:0]  LEVEL;

    sid_bus_master dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .CLKen     (CLKen),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_TYPE  (CMD_TYPE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .SID_WR    (SID_WR),
        .SID_ADDR  (SID_ADDR),
        .SID_DATAW (SID_DATAW),
        .SID_DATAR (SID_DATAR),
        .RD_VALID  (RD_VALID),
        .RD_ADDR   (RD_ADDR),
        .RD_DATA   (RD_DATA),
        .BUSY      (BUSY),
        .LEVEL     (LEVEL)
    );

    // SID read model: register value = address + 0x40.
    assign SID_DATAR = {3'b000, SID_ADDR} + 8'h40;

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_push_cyc = 0;
    int clk_mode = 0;          // 0: CLKen low, 1: CLKen high, 2: 1-in-4
    logic [1:0] ckdiv = 2'd0;
    logic edge_clken = 1'b0;
    logic [4:0] prev_addr = 5'd0;
    logic prev_wr = 1'b0;

    int         wr_cyc[$];
    logic [4:0] wr_addr[$];
    logic [7:0] wr_data[$];
    logic       wr_tick[$];
    int         rd_cyc[$];
    logic [4:0] rd_addr[$];
    logic [7:0] rd_data[$];
    logic [4:0] rd_prev_addr[$];
    logic       rd_prev_wr[$];

    always @(posedge CLK) begin
        cyc = cyc + 1;
        edge_clken = CLKen;
    end

    always @(posedge CLK) begin
        #1;
        ckdiv = ckdiv + 2'd1;
        case (clk_mode)
            1:       CLKen = 1'b1;
            2:       CLKen = (ckdiv == 2'd0);
            default: CLKen = 1'b0;
        endcase
    end

    always @(negedge CLK) begin
        if (RSTn && SID_WR) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(SID_ADDR);
            wr_data.push_back(SID_DATAW);
            wr_tick.push_back(edge_clken);
        end
        if (RSTn && RD_VALID) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(RD_ADDR);
            rd_data.push_back(RD_DATA);
            rd_prev_addr.push_back(prev_addr);
            rd_prev_wr.push_back(prev_wr);
        end
        prev_addr = SID_ADDR;
        prev_wr = SID_WR;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_tick.delete();
        rd_cyc.delete(); rd_addr.delete(); rd_data.delete();
        rd_prev_addr.delete(); rd_prev_wr.delete();
    endtask

    task automatic set_mode(input int m);
        clk_mode = m;
        repeat (2) @(negedge CLK);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [1:0] t, input logic [4:0] a, input logic [15:0] d);
        int budget;
        budget = 200;
        CMD_TYPE = t;
        CMD_ADDR = a;
        CMD_DATA = d;
        CMD_VALID = 1'b1;
        while (!CMD_READY && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (!CMD_READY) begin
            checks++;
            errors++;
            $display("FAIL push_accept: CMD_READY=%b, required 1 within 200 cycles", CMD_READY);
            CMD_VALID = 1'b0;
        end else begin
            @(posedge CLK);
            #1;
            last_push_cyc = cyc;
            @(negedge CLK);
            CMD_VALID = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (BUSY && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: BUSY=%b after %0d cycles, required 0", BUSY, budget);
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        #3 RSTn = 1'b0;
        @(negedge CLK);
        checks++; if (SID_WR !== 1'b0)    begin errors++; $display("FAIL rst_sid_wr: got %b required 0", SID_WR); end
        checks++; if (SID_ADDR !== 5'd0)  begin errors++; $display("FAIL rst_sid_addr: got %h required 00", SID_ADDR); end
        checks++; if (SID_DATAW !== 8'd0) begin errors++; $display("FAIL rst_sid_dataw: got %h required 00", SID_DATAW); end
        checks++; if (RD_VALID !== 1'b0)  begin errors++; $display("FAIL rst_rd_valid: got %b required 0", RD_VALID); end
        checks++; if (RD_ADDR !== 5'd0)   begin errors++; $display("FAIL rst_rd_addr: got %h required 00", RD_ADDR); end
        checks++; if (RD_DATA !== 8'd0)   begin errors++; $display("FAIL rst_rd_data: got %h required 00", RD_DATA); end
        checks++; if (LEVEL !== 5'd0)     begin errors++; $display("FAIL rst_level: got %0d required 0", LEVEL); end
        checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b required 0", BUSY); end
        checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", CMD_READY); end
        RSTn = 1'b1;
        @(negedge CLK);
        checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b required 1", CMD_READY); end
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        set_mode(2);
        clear_log();
        push(2'd0, 5'h18, 16'h001F);
        wait_idle(100);
        checks++; if (wr_cyc.size() != 1) begin errors++; $display("FAIL single_count: got %0d strobes required 1", wr_cyc.size()); end
        if (wr_cyc.size() >= 1) begin
            checks++; if (wr_addr[0] !== 5'h18) begin errors++; $display("FAIL single_addr: got %h required 18", wr_addr[0]); end
            checks++; if (wr_data[0] !== 8'h1F) begin errors++; $display("FAIL single_data: got %h required 1f", wr_data[0]); end
            checks++; if (wr_tick[0] !== 1'b1)  begin errors++; $display("FAIL single_tick: CLKen at strobe edge %b required 1", wr_tick[0]); end
        end
        checks++; if (SID_ADDR !== 5'h18 || SID_DATAW !== 8'h1F) begin errors++; $display("FAIL single_hold: got %h/%h required 18/1f", SID_ADDR, SID_DATAW); end
        $display("test_single_write: strobes=%0d", wr_cyc.size());
    endtask

    task automatic test_latency();
        set_mode(1);
        clear_log();
        push(2'd0, 5'h05, 16'h00AA);
        wait_idle(50);
        checks++; if (wr_cyc.size() != 1) begin errors++; $display("FAIL latency_count: got %0d strobes required 1", wr_cyc.size()); end
        if (wr_cyc.size() >= 1) begin
            checks++; if (wr_cyc[0] != last_push_cyc + 2) begin errors++; $display("FAIL latency_cycle: strobe at %0d required %0d", wr_cyc[0], last_push_cyc + 2); end
        end
        $display("test_latency: push=%0d strobe_count=%0d", last_push_cyc, wr_cyc.size());
    endtask

    task automatic test_wait_spacing(input logic [15:0] n, input int exp_gap);
        set_mode(2);
        clear_log();
        push(2'd0, 5'h00, 16'h0011);
        push(2'd2, 5'h00, n);
        push(2'd0, 5'h01, 16'h0022);
        wait_idle(300);
        checks++; if (wr_cyc.size() != 2) begin errors++; $display("FAIL wait%0d_count: got %0d strobes required 2", n, wr_cyc.size()); end
        if (wr_cyc.size() == 2) begin
            checks++; if (wr_cyc[1] - wr_cyc[0] != exp_gap) begin errors++; $display("FAIL wait%0d_gap: got %0d cycles required %0d", n, wr_cyc[1] - wr_cyc[0], exp_gap); end
            checks++; if (wr_addr[0] !== 5'h00 || wr_data[0] !== 8'h11 || wr_addr[1] !== 5'h01 || wr_data[1] !== 8'h22) begin
                errors++; $display("FAIL wait%0d_values: got %h/%h %h/%h required 00/11 01/22", n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
        $display("test_wait_spacing N=%0d: strobes=%0d", n, wr_cyc.size());
    endtask

    task automatic test_read();
        set_mode(1);
        clear_log();
`ifdef SID_BUS_MASTER_READ_EN
        push(2'd1, 5'h1B, 16'h0000);
        wait_idle(50);
        checks++; if (rd_cyc.size() != 1) begin errors++; $display("FAIL read_count: got %0d RD_VALID pulses required 1", rd_cyc.size()); end
        checks++; if (wr_cyc.size() != 0) begin errors++; $display("FAIL read_no_wr: got %0d SID_WR pulses required 0", wr_cyc.size()); end
        if (rd_cyc.size() >= 1) begin
            checks++; if (rd_addr[0] !== 5'h1B) begin errors++; $display("FAIL read_addr: got %h required 1b", rd_addr[0]); end
            checks++; if (rd_data[0] !== 8'h5B) begin errors++; $display("FAIL read_data: got %h required 5b", rd_data[0]); end
            checks++; if (rd_cyc[0] != last_push_cyc + 3) begin errors++; $display("FAIL read_latency: RD_VALID at %0d required %0d", rd_cyc[0], last_push_cyc + 3); end
            checks++; if (rd_prev_addr[0] !== 5'h1B || rd_prev_wr[0] !== 1'b0) begin errors++; $display("FAIL read_strobe_cycle: SID_ADDR=%h SID_WR=%b required 1b/0", rd_prev_addr[0], rd_prev_wr[0]); end
        end
`else
        push(2'd1, 5'h1B, 16'h0000);
        push(2'd0, 5'h02, 16'h0033);
        wait_idle(50);
        checks++; if (rd_cyc.size() != 0) begin errors++; $display("FAIL read_disabled_valid: got %0d RD_VALID pulses required 0", rd_cyc.size()); end
        checks++; if (wr_cyc.size() != 1) begin errors++; $display("FAIL read_disabled_count: got %0d strobes required 1", wr_cyc.size()); end
        if (wr_cyc.size() >= 1) begin
            checks++; if (wr_cyc[0] != last_push_cyc + 2) begin errors++; $display("FAIL read_disabled_tick: strobe at %0d required %0d", wr_cyc[0], last_push_cyc + 2); end
            checks++; if (wr_addr[0] !== 5'h02) begin errors++; $display("FAIL read_disabled_addr: got %h required 02", wr_addr[0]); end
        end
`endif
        $display("test_read: rd_pulses=%0d wr_pulses=%0d", rd_cyc.size(), wr_cyc.size());
    endtask

    // With CLKen low the first write moves into the command register, so
    // 17 pushes leave 16 queued entries and a full queue.
    task automatic test_full();
        int bad_addr;
        int bad_gap;
        set_mode(0);
        clear_log();
        for (int i = 0; i < 17; i++) begin
            push(2'd0, 5'(i), 16'(8'h80 + i));
        end
        checks++; if (LEVEL !== 5'd16)    begin errors++; $display("FAIL full_level: got %0d required 16", LEVEL); end
        checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", CMD_READY); end
        CMD_TYPE = 2'd0; CMD_ADDR = 5'h1F; CMD_DATA = 16'h00FF; CMD_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        CMD_VALID = 1'b0;
        checks++; if (LEVEL !== 5'd16) begin errors++; $display("FAIL full_ignore: got %0d required 16", LEVEL); end
        checks++; if (wr_cyc.size() != 0) begin errors++; $display("FAIL full_stall: got %0d strobes required 0", wr_cyc.size()); end
        clk_mode = 2;
        wait_idle(400);
        checks++; if (wr_cyc.size() != 17) begin errors++; $display("FAIL full_drain_count: got %0d strobes required 17", wr_cyc.size()); end
        bad_addr = 0;
        bad_gap = 0;
        for (int i = 0; i < wr_cyc.size(); i++) begin
            if (wr_addr[i] !== 5'(i) || wr_data[i] !== 8'(8'h80 + i)) bad_addr++;
            if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 4) bad_gap++;
        end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL full_order: %0d strobes out of order, required 0", bad_addr); end
        checks++; if (bad_gap != 0)  begin errors++; $display("FAIL full_spacing: %0d gaps not 4 cycles, required 0", bad_gap); end
        $display("test_full: drained=%0d", wr_cyc.size());
    endtask

    task automatic test_reset_mid_wait();
        set_mode(2);
        clear_log();
        push(2'd2, 5'h00, 16'd100);
        push(2'd0, 5'h0A, 16'h00AB);
        repeat (10) @(negedge CLK);
        checks++; if (BUSY !== 1'b1)  begin errors++; $display("FAIL midwait_busy: got %b required 1", BUSY); end
        checks++; if (LEVEL !== 5'd1) begin errors++; $display("FAIL midwait_level: got %0d required 1", LEVEL); end
        RSTn = 1'b0;
        #1;
        checks++; if (LEVEL !== 5'd0)  begin errors++; $display("FAIL rstwait_level: got %0d required 0", LEVEL); end
        checks++; if (BUSY !== 1'b0)   begin errors++; $display("FAIL rstwait_busy: got %b required 0", BUSY); end
        checks++; if (SID_WR !== 1'b0) begin errors++; $display("FAIL rstwait_wr: got %b required 0", SID_WR); end
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        clear_log();
        push(2'd0, 5'h07, 16'h0055);
        wait_idle(100);
        repeat (20) @(negedge CLK);
        checks++; if (wr_cyc.size() != 1) begin errors++; $display("FAIL rstwait_after_count: got %0d strobes required 1", wr_cyc.size()); end
        if (wr_cyc.size() >= 1) begin
            checks++; if (wr_addr[0] !== 5'h07 || wr_data[0] !== 8'h55) begin errors++; $display("FAIL rstwait_after_values: got %h/%h required 07/55", wr_addr[0], wr_data[0]); end
        end
        $display("test_reset_mid_wait: strobes_after=%0d", wr_cyc.size());
    endtask

    task automatic test_reserved();
        set_mode(0);
        clear_log();
        push(2'd0, 5'h03, 16'h0044);
        push(2'd3, 5'h1F, 16'h00EE);
        push(2'd0, 5'h04, 16'h0066);
        checks++; if (LEVEL !== 5'd1) begin errors++; $display("FAIL reserved_level: got %0d required 1", LEVEL); end
        clk_mode = 1;
        wait_idle(50);
        checks++; if (wr_cyc.size() != 2) begin errors++; $display("FAIL reserved_count: got %0d strobes required 2", wr_cyc.size()); end
        if (wr_cyc.size() == 2) begin
            checks++; if (wr_cyc[1] - wr_cyc[0] != 1) begin errors++; $display("FAIL reserved_gap: got %0d cycles required 1", wr_cyc[1] - wr_cyc[0]); end
            checks++; if (wr_addr[0] !== 5'h03 || wr_data[0] !== 8'h44 || wr_addr[1] !== 5'h04 || wr_data[1] !== 8'h66) begin
                errors++; $display("FAIL reserved_values: got %h/%h %h/%h required 03/44 04/66", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
        $display("test_reserved: strobes=%0d", wr_cyc.size());
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_latency();
        test_wait_spacing(16'd3, 16);
        test_wait_spacing(16'd0, 4);
        test_read();
        test_full();
        test_reset_mid_wait();
        test_reserved();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
